rssb_datapath: RTL and testbench

Datapath for the RSSB (reverse-subtract-and-skip-if-borrow) single-instruction processor; sits directly downstream of the control unit and consumes its select/write strobes.
Holds PC, operand-address register (op1), accumulator, word memory and the subtractor.
Returns the registered neg flag to control, closing the loop.

---
 rtl/rssb_pkg.sv | 22 ++
 rtl/rssb_mem.sv | 33 +++
 rtl/rssb_datapath.sv | 105 ++++++++++
 tb/tb_rssb_datapath.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rssb_pkg.sv
// Shared types and constants for the RSSB processor (control unit and datapath).
package rssb_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 8;

  typedef logic [DATA_W_DEF-1:0] word_t;
  typedef logic [ADDR_W_DEF-1:0] addr_t;

  typedef enum logic {
    MEM_SEL_PC  = 1'b0,
    MEM_SEL_OP1 = 1'b1
  } mem_sel_e;

  typedef enum logic {
    PC_INC1 = 1'b0,
    PC_INC2 = 1'b1
  } pc_sel_e;

  localparam addr_t HALT_ADDR = '1;

endpackage

// File: rtl/rssb_mem.sv
// RSSB word memory: one combinational read port, one synchronous write port
// shared between program loading (priority) and datapath write-back.
module rssb_mem
  import rssb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] rdata,
  input  logic              dp_we,
  input  logic [DATA_W-1:0] dp_data,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data
);

  logic [DATA_W-1:0] mem [0:2**ADDR_W-1];

  assign rdata = mem[addr];

  // Contents survive reset; only the datapath write is blocked while rst is high.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem[prog_addr] <= prog_data;
    end else if (dp_we && !rst) begin
      mem[addr] <= dp_data;
    end
  end

endmodule

// File: rtl/rssb_datapath.sv
// RSSB datapath: PC, op1, accumulator, neg flag, subtractor and word memory.
// Optional halt detection is enabled by defining RSSB_HALT_DETECT_EN.
module rssb_datapath
  import rssb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel_mem,
  input  logic              sel_pc,
  input  logic              write_op1,
  input  logic              write_acc,
  input  logic              write_mem,
  input  logic              write_pc,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
`ifdef RSSB_HALT_DETECT_EN
  output logic              halt,
`endif
  output logic              neg,
  output logic [ADDR_W-1:0] pc_o,
  output logic [DATA_W-1:0] acc_o
);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] op1;
  logic [DATA_W-1:0] acc;
  logic              neg_r;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W:0]   r_ext;
  logic [DATA_W-1:0] r;
  logic              borrow;
  logic [ADDR_W-1:0] pc_step;
  logic              run;

  assign addr = (mem_sel_e'(sel_mem) == MEM_SEL_OP1) ? op1 : pc;

  // One extra bit keeps the true sign of the difference even when r wraps.
  assign r_ext  = {rdata[DATA_W-1], rdata} - {acc[DATA_W-1], acc};
  assign r      = r_ext[DATA_W-1:0];
  assign borrow = r_ext[DATA_W];

  assign pc_step = (pc_sel_e'(sel_pc) == PC_INC2) ? ADDR_W'(2) : ADDR_W'(1);

`ifdef RSSB_HALT_DETECT_EN
  logic halt_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halt_r <= 1'b0;
    end else if (write_op1 && (rdata[ADDR_W-1:0] == {ADDR_W{1'b1}})) begin
      halt_r <= 1'b1;
    end
  end

  assign halt = halt_r;
  assign run  = !halt_r;
`else
  assign run = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc    <= '0;
      op1   <= '0;
      acc   <= '0;
      neg_r <= 1'b0;
    end else begin
      if (write_op1) begin
        op1 <= rdata[ADDR_W-1:0];
      end
      if (write_acc && run) begin
        acc   <= r;
        neg_r <= borrow;
      end
      if (write_pc && run) begin
        pc <= pc + pc_step;
      end
    end
  end

  rssb_mem #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .rdata    (rdata),
    .dp_we    (write_mem && run),
    .dp_data  (r),
    .prog_we  (prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data)
  );

  assign pc_o  = pc;
  assign acc_o = acc;
  assign neg   = neg_r;

endmodule

// File: tb/tb_rssb_datapath.sv
// Scoreboard bench for rssb_datapath: a behavioural model pushes expected
// register/memory values per cycle, which are popped and compared after the edge.
module tb_rssb_datapath;
  import rssb_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel_mem = 1'b0, sel_pc = 1'b0;
  logic       write_op1 = 1'b0, write_acc = 1'b0, write_mem = 1'b0, write_pc = 1'b0;
  logic       prog_we = 1'b0;
  logic [7:0] prog_addr = '0, prog_data = '0;
  logic       neg;
  logic [7:0] pc_o, acc_o;
`ifdef RSSB_HALT_DETECT_EN
  logic       halt;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [2:0] kind;
    logic [7:0] addr;
    logic [7:0] exp;
  } exp_t;

  localparam logic [2:0] K_PC = 3'd0, K_ACC = 3'd1, K_NEG = 3'd2, K_MEM = 3'd3, K_HALT = 3'd4;

  exp_t expQ[$];

  logic [7:0] m_pc, m_op1, m_acc;
  logic       m_neg, m_halt;
  logic [7:0] m_mem [0:255];

  rssb_datapath dut (
    .clk      (clk),
    .rst      (rst),
    .sel_mem  (sel_mem),
    .sel_pc   (sel_pc),
    .write_op1(write_op1),
    .write_acc(write_acc),
    .write_mem(write_mem),
    .write_pc (write_pc),
    .prog_we  (prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
`ifdef RSSB_HALT_DETECT_EN
    .halt     (halt),
`endif
    .neg      (neg),
    .pc_o     (pc_o),
    .acc_o    (acc_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic pushExp(input logic [2:0] kind, input logic [7:0] addr, input logic [7:0] exp);
    exp_t e;
    e.kind = kind;
    e.addr = addr;
    e.exp  = exp;
    expQ.push_back(e);
  endtask

  task automatic drainQueue();
    exp_t e;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      case (e.kind)
        K_PC:  checkOutput("pc", pc_o, e.exp);
        K_ACC: checkOutput("acc", acc_o, e.exp);
        K_NEG: checkOutput("neg", {7'd0, neg}, e.exp);
        K_MEM: checkOutput($sformatf("mem[%0d]", e.addr), dut.u_mem.mem[e.addr], e.exp);
`ifdef RSSB_HALT_DETECT_EN
        K_HALT: checkOutput("halt", {7'd0, halt}, e.exp);
`endif
        default: ;
      endcase
    end
  endtask

  task automatic pushRegs();
    pushExp(K_PC, 8'd0, m_pc);
    pushExp(K_ACC, 8'd0, m_acc);
    pushExp(K_NEG, 8'd0, {7'd0, m_neg});
`ifdef RSSB_HALT_DETECT_EN
    pushExp(K_HALT, 8'd0, {7'd0, m_halt});
`endif
  endtask

  // Drives one cycle of strobes, advances the model, checks after the edge.
  task automatic applyStimulus(input logic sm, input logic sp, input logic wo, input logic wa,
                               input logic wm, input logic wp, input logic pwe,
                               input logic [7:0] paddr, input logic [7:0] pdata);
    logic [7:0] a, rd, r;
    logic       brw, run;
    int         re;
    @(negedge clk);
    sel_mem = sm; sel_pc = sp; write_op1 = wo; write_acc = wa;
    write_mem = wm; write_pc = wp; prog_we = pwe; prog_addr = paddr; prog_data = pdata;
    a   = sm ? m_op1 : m_pc;
    rd  = m_mem[a];
    re  = int'($signed(rd)) - int'($signed(m_acc));
    r   = 8'(re);
    brw = (re < 0);
`ifdef RSSB_HALT_DETECT_EN
    run = !m_halt;
`else
    run = 1'b1;
`endif
    if (pwe) begin
      m_mem[paddr] = pdata;
      pushExp(K_MEM, paddr, pdata);
    end else if (wm && run && !rst) begin
      m_mem[a] = r;
      pushExp(K_MEM, a, r);
    end
    if (!rst) begin
`ifdef RSSB_HALT_DETECT_EN
      if (wo && rd == HALT_ADDR) m_halt = 1'b1;
`endif
      if (wo) m_op1 = rd;
      if (wa && run) begin
        m_acc = r;
        m_neg = brw;
      end
      if (wp && run) m_pc = m_pc + (sp ? 8'd2 : 8'd1);
    end
    pushRegs();
    @(posedge clk);
    #1;
    drainQueue();
    {sel_mem, sel_pc, write_op1, write_acc, write_mem, write_pc, prog_we} = '0;
  endtask

  task automatic progLoad(input logic [7:0] a, input logic [7:0] d);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, a, d);
  endtask

  task automatic stepOp(input logic sm, input logic sp, input logic wo, input logic wa,
                        input logic wm, input logic wp);
    applyStimulus(sm, sp, wo, wa, wm, wp, 1'b0, 8'd0, 8'd0);
  endtask

  task automatic modelReset();
    m_pc = '0; m_op1 = '0; m_acc = '0; m_neg = 1'b0; m_halt = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    modelReset();
    #1;
    pushRegs();
    drainQueue();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic sm, wm;
    modelReset();
    // Preload all of memory while reset is held; mem[5] is the retention marker.
    for (int i = 0; i < 256; i++) begin
      progLoad(8'(i), (i == 5) ? 8'h33 : 8'((i * 37 + 11) % 251));
    end
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] random strobe phase");
    for (int i = 0; i < 24; i++) begin
      sm = 1'($urandom_range(0, 1));
      wm = 1'($urandom_range(0, 1));
      if ((sm ? m_op1 : m_pc) == 8'd5) wm = 1'b0;
      stepOp(sm, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), wm, 1'($urandom_range(0, 1)));
    end

    $display("[TB] reset asserted mid-cycle");
    @(negedge clk);
    sel_mem = 1'b1; write_op1 = 1'b1; write_acc = 1'b1; write_mem = 1'b1; write_pc = 1'b1;
    #2;
    rst = 1'b1;
    modelReset();
    #1;
    pushRegs();
    drainQueue();
    @(posedge clk);
    #1;
    pushExp(K_MEM, 8'd5, 8'h33);
    pushExp(K_MEM, 8'd0, m_mem[0]);
    pushRegs();
    drainQueue();
    {sel_mem, write_op1, write_acc, write_mem, write_pc} = '0;
    @(negedge clk);
    rst = 1'b0;

    // op1 cleared by reset: operand read targets mem[0].
    pushExp(K_ACC, 8'd0, m_mem[0]);
    stepOp(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("[TB] directed two-instruction program");
    doReset();
    progLoad(8'd0, 8'd10); progLoad(8'd10, 8'd7);
    progLoad(8'd1, 8'd11); progLoad(8'd11, 8'd3);
    stepOp(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    pushExp(K_ACC, 8'd0, 8'd7); pushExp(K_MEM, 8'd10, 8'd7); pushExp(K_NEG, 8'd0, 8'd0);
    stepOp(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    pushExp(K_PC, 8'd0, 8'd1);
    stepOp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    stepOp(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    pushExp(K_ACC, 8'd0, 8'hFC); pushExp(K_MEM, 8'd11, 8'hFC); pushExp(K_NEG, 8'd0, 8'd1);
    stepOp(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    pushExp(K_PC, 8'd0, 8'd3);
    stepOp(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("[TB] overflow keeps true sign");
    doReset();
    progLoad(8'd0, 8'd30); progLoad(8'd30, 8'h01);
    progLoad(8'd1, 8'd31); progLoad(8'd31, 8'h80);
    stepOp(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    pushExp(K_ACC, 8'd0, 8'h01);
    stepOp(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    stepOp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    stepOp(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    pushExp(K_ACC, 8'd0, 8'h7F); pushExp(K_NEG, 8'd0, 8'd1); pushExp(K_MEM, 8'd31, 8'h7F);
    stepOp(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    $display("[TB] PC wrap");
    doReset();
    for (int i = 0; i < 127; i++) stepOp(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    pushExp(K_PC, 8'd0, 8'd255);
    stepOp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    pushExp(K_PC, 8'd0, 8'd1);
    stepOp(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 127; i++) stepOp(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    pushExp(K_PC, 8'd0, 8'd0);
    stepOp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("[TB] program write beats datapath write");
    progLoad(8'd0, 8'h11);
    pushExp(K_ACC, 8'd0, 8'h11); pushExp(K_MEM, 8'd0, 8'h5A);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0, 8'h5A);

    $display("[TB] fetch of all-ones operand address");
    progLoad(8'd0, 8'hFF);
    progLoad(8'hFF, 8'h40);
    stepOp(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef RSSB_HALT_DETECT_EN
    pushExp(K_HALT, 8'd0, 8'd1);
    pushExp(K_PC, 8'd0, 8'd0);
    stepOp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    pushExp(K_ACC, 8'd0, 8'h11);
    stepOp(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    pushExp(K_MEM, 8'd7, 8'hC3);
    progLoad(8'd7, 8'hC3);
`else
    pushExp(K_ACC, 8'd0, 8'h2F);
    stepOp(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    pushExp(K_PC, 8'd0, 8'd1);
    stepOp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
